// File: rtl/spi_boot_loader_if.sv
// spi_boot_loader_if: SRAM byte-write handshake between the boot loader and the arbiter.
interface spi_boot_loader_if #(parameter int ADDR_WIDTH = 18);
  logic [ADDR_WIDTH-1:0] boot_addr;
  logic [7:0]            boot_data;
  logic                  boot_wr_req;
  logic                  boot_wr_ack;
  modport master (output boot_addr, boot_data, boot_wr_req, input boot_wr_ack);
  modport slave  (input boot_addr, boot_data, boot_wr_req, output boot_wr_ack);
endinterface

// File: rtl/spi_boot_loader.sv
// spi_boot_loader: receives the boot ROM image over SPI and issues byte writes into SRAM,
// holding the machine in boot until the transfer has ended and the last write is acknowledged.
module spi_boot_loader #(
  parameter int                  ADDR_WIDTH      = 18,
  parameter logic [ADDR_WIDTH:0] BOOT_START_ADDR = 'h0C000,
  parameter logic [ADDR_WIDTH:0] BOOT_END_ADDR   = 'h0FFFF,
  parameter int                  SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              arm_ss,
  input  logic              arm_sclk,
  input  logic              arm_mosi,
  spi_boot_loader_if.master bus,
  output logic              boot_active,
  output logic              boot_done,
  output logic              boot_overrun
);
  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;
  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_ss_s, r_sclk_s, r_mosi_s;
  logic                   r_ss_d, r_sclk_d;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift;
  logic [ADDR_WIDTH:0]    r_addr_cnt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [7:0]             r_data;
  logic                   r_wr_req, r_overrun;
  logic                   w_ss, w_sclk, w_mosi, w_sclk_rise, w_ss_rise, w_byte_done, w_in_range, w_ack;
  logic [7:0]             w_byte;
  assign w_ss        = r_ss_s[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;
  assign w_byte      = {r_shift, w_mosi};
  assign w_byte_done = (r_state == RECV) && w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_in_range  = r_addr_cnt <= BOOT_END_ADDR;
  assign w_ack       = bus.boot_wr_ack & r_wr_req;
  // synchronizers idle high so reset never looks like an ss or sclk edge
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      r_ss_s   <= '1;
      r_sclk_s <= '1;
      r_mosi_s <= '1;
      r_ss_d   <= 1'b1;
      r_sclk_d <= 1'b1;
    end else begin
      r_ss_s   <= {r_ss_s[SYNC_STAGES-2:0], arm_ss};
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], arm_sclk};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], arm_mosi};
      r_ss_d   <= w_ss;
      r_sclk_d <= w_sclk;
    end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_ss ? IDLE : RECV;
      RECV:    w_next = w_ss_rise ? DRAIN : RECV;
      DRAIN:   w_next = r_wr_req ? DRAIN : DONE;
      default: w_next = DONE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (r_state != RECV) begin
      r_bit_cnt <= '0;
    end else if (w_sclk_rise) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_shift   <= w_byte[6:0];
    end
  // an overrun still consumes its address so later bytes land where the image expects them
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      r_addr_cnt <= BOOT_START_ADDR;
      r_addr     <= BOOT_START_ADDR[ADDR_WIDTH-1:0];
      r_data     <= '0;
      r_wr_req   <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_byte_done && w_in_range) begin
      r_addr_cnt <= r_addr_cnt + (ADDR_WIDTH+1)'(1);
      if (!r_wr_req || w_ack) begin
        r_addr   <= r_addr_cnt[ADDR_WIDTH-1:0];
        r_data   <= w_byte;
        r_wr_req <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_ack) begin
      r_wr_req <= 1'b0;
    end
  assign bus.boot_addr   = r_addr;
  assign bus.boot_data   = r_data;
  assign bus.boot_wr_req = r_wr_req;
  assign boot_active     = r_state != DONE;
  assign boot_done       = r_state == DONE;
  assign boot_overrun    = r_overrun;
endmodule

// File: tb/tb_spi_boot_loader.sv
// tb_spi_boot_loader: directed and randomized SPI boot transfers into a full-map loader and a
// 64-byte-window loader, with writes checked against a list computed from the bytes sent.
module tb_spi_boot_loader;
  typedef logic [25:0] wq_t[$];
  logic clk, reset_b, ss, sclk, mosi;
  logic act0, done0, ovr0, act1, done1, ovr1;
  int total, bad, mode0, mode1, dly0, dly1, c0, c1;
  bit force0;
  wq_t wq0, wq1;
  logic [7:0] sent[$];
  logic [7:0] b1, b2;

  spi_boot_loader_if #(.ADDR_WIDTH(18)) bif0();
  spi_boot_loader_if #(.ADDR_WIDTH(18)) bif1();

  spi_boot_loader u_dut0 (.clk(clk), .reset_b(reset_b), .arm_ss(ss), .arm_sclk(sclk), .arm_mosi(mosi),
    .bus(bif0), .boot_active(act0), .boot_done(done0), .boot_overrun(ovr0));
  spi_boot_loader #(.BOOT_START_ADDR(19'h0FFC0)) u_dut1 (.clk(clk), .reset_b(reset_b), .arm_ss(ss),
    .arm_sclk(sclk), .arm_mosi(mosi), .bus(bif1), .boot_active(act1), .boot_done(done1), .boot_overrun(ovr1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // arbiter models: ack mid-cycle after a programmable delay, or on demand for dut0
  initial begin
    bif0.boot_wr_ack = 0;
    bif1.boot_wr_ack = 0;
    c0 = 0;
    c1 = 0;
    forever begin
      @(posedge clk);
      #2;
      bif0.boot_wr_ack = 0;
      bif1.boot_wr_ack = 0;
      if (bif0.boot_wr_req) c0++; else c0 = 0;
      if (bif1.boot_wr_req) c1++; else c1 = 0;
      if (bif0.boot_wr_req && (force0 || (mode0 != 0 && c0 >= dly0))) begin
        bif0.boot_wr_ack = 1;
        c0 = 0;
        wq0.push_back({bif0.boot_addr, bif0.boot_data});
      end
      if (bif1.boot_wr_req && mode1 != 0 && c1 >= dly1) begin
        bif1.boot_wr_ack = 1;
        c1 = 0;
        wq1.push_back({bif1.boot_addr, bif1.boot_data});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input bit coincide);
    for (int i = 0; i < nbits; i++) begin
      sclk = 0;
      mosi = b[7-i];
      repeat (3) @(negedge clk);
      sclk = 1;
      if (coincide && i == 7) begin
        @(negedge clk);
        force0 = 1;
        @(negedge clk);
        force0 = 0;
      end else repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_rand(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      send_bits(b, 8, 0);
    end
  endtask

  task automatic start_xfer();
    ss = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_xfer();
    ss = 1;
    for (int i = 0; i < 300; i++) begin
      if (done0 && done1) break;
      @(negedge clk);
    end
    chk("done0_wait", done0, 1);
    chk("done1_wait", done1, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_b = 0;
    ss = 1;
    sclk = 1;
    mosi = 1;
    force0 = 0;
    #1;
    chk("rst_active", act0, 1);
    chk("rst_req", bif0.boot_wr_req, 0);
    chk("rst_addr", bif0.boot_addr, 18'h0C000);
    repeat (2) @(negedge clk);
    reset_b = 1;
    wq0.delete();
    wq1.delete();
    sent.delete();
    @(negedge clk);
  endtask

  // expected writes: byte i goes to start+i unless that is past the end of the boot region
  task automatic check_writes(input string tag, input wq_t q, input int start);
    int n = 0;
    foreach (sent[i]) if (start + i <= 'h0FFFF) n++;
    chk({tag, "_count"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) chk(tag, q[i], {18'(start + i), sent[i]});
  endtask

  initial begin
    total = 0;
    bad = 0;
    mode0 = 1;
    mode1 = 1;
    dly0 = 3;
    dly1 = 3;
    force0 = 0;
    reset_b = 0;
    ss = 1;
    sclk = 1;
    mosi = 1;
    repeat (2) @(negedge clk);
    do_reset();
    chk("init_data", bif0.boot_data, 0);
    chk("init_done", done0, 0);
    chk("init_ovr", ovr0, 0);
    chk("init_active", act0, 1);
    chk("init_addr1", bif1.boot_addr, 18'h0FFC0);

    // single byte: request one cycle after the 8th synchronized sclk rise, held until ack
    mode0 = 0;
    start_xfer();
    send_bits(8'hA5, 7, 0);
    sclk = 0;
    mosi = 1;
    repeat (3) @(negedge clk);
    sclk = 1;
    @(negedge clk);
    chk("tim_req_early1", bif0.boot_wr_req, 0);
    @(negedge clk);
    chk("tim_req_early2", bif0.boot_wr_req, 0);
    @(negedge clk);
    chk("tim_req", bif0.boot_wr_req, 1);
    chk("tim_addr", bif0.boot_addr, 18'h0C000);
    chk("tim_data", bif0.boot_data, 8'hA5);
    repeat (10) @(negedge clk);
    chk("tim_hold_req", bif0.boot_wr_req, 1);
    chk("tim_hold_data", bif0.boot_data, 8'hA5);
    force0 = 1;
    @(negedge clk);
    force0 = 0;
    @(negedge clk);
    chk("tim_req_drop", bif0.boot_wr_req, 0);
    sent.push_back(8'hA5);
    end_xfer();
    check_writes("tim_wr", wq0, 'h0C000);
    mode0 = 1;

    // full image through the 64-byte window
    do_reset();
    start_xfer();
    for (int i = 0; i < 64; i++) begin
      sent.push_back(8'(i));
      send_bits(8'(i), 8, 0);
    end
    repeat (10) @(negedge clk);
    chk("full_active_pre", act1, 1);
    chk("full_done_pre", done1, 0);
    end_xfer();
    check_writes("full_wr1", wq1, 'h0FFC0);
    check_writes("full_wr0", wq0, 'h0C000);
    chk("full_ovr", ovr1, 0);
    chk("full_active", act1, 0);

    // over-length with random ack latency
    do_reset();
    dly1 = $urandom_range(1, 12);
    start_xfer();
    send_rand(66);
    end_xfer();
    check_writes("over_wr", wq1, 'h0FFC0);
    chk("over_last_addr", bif1.boot_addr, 18'h0FFFF);
    chk("over_ovr", ovr1, 0);
    dly1 = 3;

    // partial final byte discarded; DONE ignores a later transfer
    do_reset();
    start_xfer();
    send_rand(2);
    send_bits(8'($urandom), 5, 0);
    end_xfer();
    check_writes("part_wr", wq0, 'h0C000);
    start_xfer();
    send_bits(8'($urandom), 8, 0);
    ss = 1;
    repeat (20) @(negedge clk);
    chk("part_ignored", wq0.size(), 2);
    chk("part_done", done0, 1);
    chk("part_req", bif0.boot_wr_req, 0);

    // overrun: second byte dropped but its address consumed
    do_reset();
    mode0 = 0;
    start_xfer();
    send_bits(8'h11, 8, 0);
    send_bits(8'h22, 8, 0);
    @(negedge clk);
    chk("ovr_flag", ovr0, 1);
    chk("ovr_req", bif0.boot_wr_req, 1);
    chk("ovr_addr", bif0.boot_addr, 18'h0C000);
    chk("ovr_data", bif0.boot_data, 8'h11);
    force0 = 1;
    @(negedge clk);
    force0 = 0;
    mode0 = 1;
    send_bits(8'h33, 8, 0);
    end_xfer();
    chk("ovr_count", wq0.size(), 2);
    if (wq0.size() == 2) begin
      chk("ovr_wr0", wq0[0], {18'h0C000, 8'h11});
      chk("ovr_wr1", wq0[1], {18'h0C002, 8'h33});
    end
    chk("ovr_sticky", ovr0, 1);

    // ack lands in the same cycle the next byte completes
    do_reset();
    mode0 = 0;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    sent.push_back(b1);
    sent.push_back(b2);
    start_xfer();
    send_bits(b1, 8, 0);
    send_bits(b2, 8, 1);
    @(negedge clk);
    chk("coin_req", bif0.boot_wr_req, 1);
    chk("coin_addr", bif0.boot_addr, 18'h0C001);
    chk("coin_data", bif0.boot_data, b2);
    chk("coin_ovr", ovr0, 0);
    mode0 = 1;
    end_xfer();
    check_writes("coin_wr", wq0, 'h0C000);

    // asynchronous reset mid-transfer, then a fresh load
    do_reset();
    start_xfer();
    send_rand(100);
    reset_b = 0;
    ss = 1;
    #1;
    chk("mrst_active", act0, 1);
    chk("mrst_req", bif0.boot_wr_req, 0);
    chk("mrst_addr", bif0.boot_addr, 18'h0C000);
    chk("mrst_done", done0, 0);
    repeat (2) @(negedge clk);
    reset_b = 1;
    wq0.delete();
    wq1.delete();
    sent.delete();
    @(negedge clk);
    start_xfer();
    send_rand(4);
    repeat (10) @(negedge clk);
    chk("mrst_active_pre", act0, 1);
    end_xfer();
    check_writes("mrst_wr", wq0, 'h0C000);
    chk("mrst_active_post", act0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
